// File: rtl/inst_fetch_pkg.sv
// Shared constants, state encodings and bundles for the fetch stage.
// The IF/ID bundle and the helper are reused by the stage register.
package inst_fetch_pkg;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic BRANCH     = 1'b1;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;

    // Stall vector bit positions
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } if_id_t;

    // Sequential successor; wraps modulo 2^32
    function automatic logic [INST_ADDR_W-1:0] pc_inc(
        input logic [INST_ADDR_W-1:0] pc
    );
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: pass, bubble or hold the (pc, inst) pair.
// stall[0] holds IF, stall[1] holds ID.
module if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             stall,
    input  logic                   accept,
    input  logic [INST_ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0]      if_inst,
    output logic [INST_ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0]      id_inst
);

    if_id_t q;

    logic if_hold;
    logic id_hold;

    assign if_hold = (stall[0] == STOP);
    assign id_hold = (stall[1] == STOP);

    // Hold when both stages stall, bubble when only IF stalls or
    // nothing was accepted, otherwise take the fetched word.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            q <= '0;
        end else if (if_hold && id_hold) begin
            q <= q;
        end else if (if_hold) begin
            q <= '0;
        end else if (accept) begin
            q <= {if_pc, if_inst};
        end else begin
            q <= '0;
        end
    end

    assign id_pc   = q.pc;
    assign id_inst = q.inst;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, single-outstanding req/ack fetch, 1-entry
// skid buffer, delay-slot redirect latch, and the IF/ID register.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        stallreq_o
);

    fetch_state_t state;

    logic [31:0] pc_q;
    logic [31:0] buf_q;
    logic        buf_full;
    logic [31:0] redirect_pc;
    logic        redirect_valid;

    logic        if_hold;
    logic        id_hold;
    logic        in_fetch;
    logic        in_hold;
    logic        accept;
    logic        branch_leaves;
    logic [31:0] target_aligned;
    logic [31:0] pc_next;
    logic [31:0] if_inst;

    // Stall bits 0 and 3..5 belong to other stages; low target
    // bits are dropped because fetch addresses are word aligned.
    logic unused_bits;
    assign unused_bits = ^{stall_i[5:3], stall_i[0], branch_target_i[1:0]};

    assign if_hold  = (stall_i[STALL_IF] == STOP);
    assign id_hold  = (stall_i[STALL_ID] == STOP);
    assign in_fetch = (state == ST_FETCH);
    assign in_hold  = (state == ST_HOLD);

    assign accept = !if_hold
                 && ((in_fetch && imem_ack_i) || (in_hold && buf_full));

    assign branch_leaves  = (branch_flag_i == BRANCH) && !id_hold;
    assign target_aligned = {branch_target_i[31:2], 2'b00};

    // A latched redirect outranks a live branch from ID.
    always_comb begin
        pc_next = pc_inc(pc_q);
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (branch_flag_i == BRANCH) begin
            pc_next = target_aligned;
        end
    end

    assign if_inst = in_fetch ? imem_rdata_i : buf_q;

    assign imem_req_o  = (rst != RST_ENABLE) && in_fetch;
    assign imem_addr_o = pc_q;
    assign stallreq_o  = (imem_req_o && !imem_ack_i) ? STOP : NO_STOP;

    // Fetch FSM: request in FETCH, park an unaccepted word in HOLD.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= ST_IDLE;
            buf_q    <= ZERO_WORD;
            buf_full <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack_i && !accept) begin
                        state    <= ST_HOLD;
                        buf_q    <= imem_rdata_i;
                        buf_full <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        state    <= ST_FETCH;
                        buf_full <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // PC advances on accept; a branch leaving ID before its delay
    // slot is accepted is remembered until that accept happens.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc_q           <= RESET_PC;
            redirect_pc    <= ZERO_WORD;
            redirect_valid <= 1'b0;
        end else if (accept) begin
            pc_q           <= pc_next;
            redirect_valid <= 1'b0;
        end else if (branch_leaves) begin
            redirect_pc    <= target_aligned;
            redirect_valid <= 1'b1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall_i[STALL_ID:STALL_IF]),
        .accept  (accept),
        .if_pc   (pc_q),
        .if_inst (if_inst),
        .id_pc   (id_pc_o),
        .id_inst (id_inst_o)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory model with per-address
// ack delay, decoder stand-in for branches, ID-side scoreboard.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        stallreq_o;

    logic [1:0]  stall_v;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          delay_map[logic [31:0]];
    int          waited;
    bit          br_en;
    logic [31:0] br_pc;
    logic [31:0] br_tgt;
    bit          hold_prev;
    int          n_checks;
    int          n_pass;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .stallreq_o      (stallreq_o)
    );

    always #5 clk = ~clk;

    assign stall_i = {3'b000, stall_v, 1'b0};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hC0, a[23:0]} ^ 32'h0000_5A00;
    endfunction

    always @(posedge clk) hold_prev <= (stall_v == 2'b11);

    // Every new non-bubble instruction in ID must be the next expected one
    always @(negedge clk) begin
        if (!rst && !hold_prev && id_inst_o !== 32'h0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_extra: got pc %h inst %h, want no delivery",
                         id_pc_o, id_inst_o);
            end else begin
                e = exp_q.pop_front();
                if (id_pc_o !== e.pc || id_inst_o !== e.inst)
                    $display("FAIL sb_order: got pc %h inst %h, want pc %h inst %h",
                             id_pc_o, id_inst_o, e.pc, e.inst);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic drive();
        int d;
        branch_flag_i   = br_en && (id_inst_o != 32'h0) && (id_pc_o == br_pc);
        branch_target_i = br_tgt;
        if (imem_req_o) begin
            d = delay_map.exists(imem_addr_o) ? delay_map[imem_addr_o] : 0;
            imem_ack_i   = (waited >= d);
            imem_rdata_i = imem_ack_i ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
        end else begin
            imem_ack_i   = 1'b0;
            imem_rdata_i = 32'hDEAD_BEEF;
        end
        #1;
    endtask

    task automatic tick();
        logic was_req;
        was_req = imem_req_o;
        @(posedge clk);
        if (imem_ack_i) waited = 0;
        else if (was_req) waited++;
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        stall_v         = 2'b00;
        br_en           = 1'b0;
        br_pc           = 32'h0;
        br_tgt          = 32'h0;
        imem_ack_i      = 1'b0;
        imem_rdata_i    = 32'h0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        waited          = 0;
        delay_map.delete();
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        imem_ack_i = 1'b1;
        #1;
        n_checks++;
        if (imem_req_o !== 1'b0)
            $display("FAIL rst_req: got %b, want 0", imem_req_o);
        else n_pass++;
        n_checks++;
        if (stallreq_o !== 1'b0)
            $display("FAIL rst_stallreq: got %b, want 0", stallreq_o);
        else n_pass++;
        n_checks++;
        if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0)
            $display("FAIL rst_id: got pc %h inst %h, want 0 0", id_pc_o, id_inst_o);
        else n_pass++;
        imem_ack_i = 1'b0;
        rst = 1'b0;
        drive();
        n_checks++;
        if (imem_req_o !== 1'b0)
            $display("FAIL rst_idle_req: got %b, want 0", imem_req_o);
        else n_pass++;
        tick();
        drive();
        n_checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0})
            $display("FAIL rst_first_fetch: got req %b addr %h, want req 1 addr 0",
                     imem_req_o, imem_addr_o);
        else n_pass++;
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset();
        drive();
        tick();
        for (int i = 0; i < 8; i++) begin
            a = 32'(i * 4);
            drive();
            n_checks++;
            if ({imem_req_o, imem_addr_o} !== {1'b1, a})
                $display("FAIL zw_addr: got req %b addr %h, want req 1 addr %h",
                         imem_req_o, imem_addr_o, a);
            else n_pass++;
            n_checks++;
            if (stallreq_o !== 1'b0)
                $display("FAIL zw_stallreq: got %b, want 0", stallreq_o);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (id_pc_o !== a - 32'd4)
                    $display("FAIL zw_trail: got id_pc %h, want %h", id_pc_o, a - 32'd4);
                else n_pass++;
            end
            exp_q.push_back('{pc: a, inst: mem_word(a)});
            tick();
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL zw_drain: got %0d pending, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_ack_delay();
        logic [31:0] a;
        do_reset();
        delay_map[32'h8] = 3;
        drive();
        tick();
        for (int i = 0; i < 2; i++) begin
            a = 32'(i * 4);
            drive();
            n_checks++;
            if (imem_addr_o !== a)
                $display("FAIL dl_addr: got %h, want %h", imem_addr_o, a);
            else n_pass++;
            exp_q.push_back('{pc: a, inst: mem_word(a)});
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive();
            n_checks++;
            if ({imem_req_o, imem_addr_o, stallreq_o} !== {1'b1, 32'h8, 1'b1})
                $display("FAIL dl_wait: got req %b addr %h stallreq %b, want 1 00000008 1",
                         imem_req_o, imem_addr_o, stallreq_o);
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if (id_inst_o !== 32'h0)
                    $display("FAIL dl_bubble: got %h, want 0", id_inst_o);
                else n_pass++;
            end
            tick();
        end
        drive();
        n_checks++;
        if ({imem_req_o, imem_addr_o, stallreq_o} !== {1'b1, 32'h8, 1'b0})
            $display("FAIL dl_ack: got req %b addr %h stallreq %b, want 1 00000008 0",
                     imem_req_o, imem_addr_o, stallreq_o);
        else n_pass++;
        exp_q.push_back('{pc: 32'h8, inst: mem_word(32'h8)});
        tick();
        drive();
        n_checks++;
        if (imem_addr_o !== 32'hC)
            $display("FAIL dl_next: got %h, want 0000000c", imem_addr_o);
        else n_pass++;
        exp_q.push_back('{pc: 32'hC, inst: mem_word(32'hC)});
        tick();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL dl_drain: got %0d pending, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_branch_late();
        logic [31:0] a;
        do_reset();
        br_en  = 1'b1;
        br_pc  = 32'h10;
        br_tgt = 32'h40;
        delay_map[32'h14] = 2;
        drive();
        tick();
        for (int i = 0; i < 5; i++) begin
            a = 32'(i * 4);
            drive();
            n_checks++;
            if (imem_addr_o !== a)
                $display("FAIL bl_addr: got %h, want %h", imem_addr_o, a);
            else n_pass++;
            exp_q.push_back('{pc: a, inst: mem_word(a)});
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive();
            n_checks++;
            if ({imem_req_o, imem_addr_o, stallreq_o} !== {1'b1, 32'h14, 1'b1})
                $display("FAIL bl_wait: got req %b addr %h stallreq %b, want 1 00000014 1",
                         imem_req_o, imem_addr_o, stallreq_o);
            else n_pass++;
            tick();
        end
        drive();
        n_checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h14})
            $display("FAIL bl_slot: got req %b addr %h, want 1 00000014",
                     imem_req_o, imem_addr_o);
        else n_pass++;
        exp_q.push_back('{pc: 32'h14, inst: mem_word(32'h14)});
        tick();
        drive();
        n_checks++;
        if (imem_addr_o !== 32'h40)
            $display("FAIL bl_target: got %h, want 00000040", imem_addr_o);
        else n_pass++;
        exp_q.push_back('{pc: 32'h40, inst: mem_word(32'h40)});
        tick();
        drive();
        n_checks++;
        if (imem_addr_o !== 32'h44)
            $display("FAIL bl_after: got %h, want 00000044", imem_addr_o);
        else n_pass++;
        exp_q.push_back('{pc: 32'h44, inst: mem_word(32'h44)});
        tick();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL bl_drain: got %0d pending, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_branch_same();
        logic [31:0] a;
        do_reset();
        br_en  = 1'b1;
        br_pc  = 32'h10;
        br_tgt = 32'h42;
        drive();
        tick();
        for (int i = 0; i < 6; i++) begin
            a = 32'(i * 4);
            drive();
            n_checks++;
            if (imem_addr_o !== a)
                $display("FAIL bs_addr: got %h, want %h", imem_addr_o, a);
            else n_pass++;
            exp_q.push_back('{pc: a, inst: mem_word(a)});
            tick();
        end
        drive();
        n_checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h40})
            $display("FAIL bs_target: got req %b addr %h, want 1 00000040",
                     imem_req_o, imem_addr_o);
        else n_pass++;
        exp_q.push_back('{pc: 32'h40, inst: mem_word(32'h40)});
        tick();
        drive();
        n_checks++;
        if (imem_addr_o !== 32'h44)
            $display("FAIL bs_after: got %h, want 00000044", imem_addr_o);
        else n_pass++;
        exp_q.push_back('{pc: 32'h44, inst: mem_word(32'h44)});
        tick();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL bs_drain: got %0d pending, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_stall_hold();
        logic [31:0] a;
        do_reset();
        drive();
        tick();
        for (int i = 0; i < 2; i++) begin
            a = 32'(i * 4);
            drive();
            exp_q.push_back('{pc: a, inst: mem_word(a)});
            tick();
        end
        stall_v = 2'b11;
        drive();
        n_checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h8})
            $display("FAIL sh_capture: got req %b addr %h, want 1 00000008",
                     imem_req_o, imem_addr_o);
        else n_pass++;
        tick();
        for (int k = 0; k < 4; k++) begin
            drive();
            n_checks++;
            if ({imem_req_o, stallreq_o} !== 2'b00)
                $display("FAIL sh_req: got req %b stallreq %b, want 0 0",
                         imem_req_o, stallreq_o);
            else n_pass++;
            n_checks++;
            if (id_pc_o !== 32'h4 || id_inst_o !== mem_word(32'h4))
                $display("FAIL sh_hold: got pc %h inst %h, want pc 00000004 inst %h",
                         id_pc_o, id_inst_o, mem_word(32'h4));
            else n_pass++;
            tick();
        end
        stall_v = 2'b00;
        drive();
        n_checks++;
        if (imem_req_o !== 1'b0)
            $display("FAIL sh_release_req: got %b, want 0", imem_req_o);
        else n_pass++;
        exp_q.push_back('{pc: 32'h8, inst: mem_word(32'h8)});
        tick();
        drive();
        n_checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'hC})
            $display("FAIL sh_next: got req %b addr %h, want 1 0000000c",
                     imem_req_o, imem_addr_o);
        else n_pass++;
        exp_q.push_back('{pc: 32'hC, inst: mem_word(32'hC)});
        tick();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL sh_drain: got %0d pending, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        do_reset();
        delay_map[32'h20] = 5;
        drive();
        tick();
        for (int i = 0; i < 8; i++) begin
            a = 32'(i * 4);
            drive();
            exp_q.push_back('{pc: a, inst: mem_word(a)});
            tick();
        end
        drive();
        n_checks++;
        if ({imem_req_o, imem_addr_o, stallreq_o} !== {1'b1, 32'h20, 1'b1})
            $display("FAIL rm_wait: got req %b addr %h stallreq %b, want 1 00000020 1",
                     imem_req_o, imem_addr_o, stallreq_o);
        else n_pass++;
        tick();
        rst          = 1'b1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem_word(32'h20);
        #1;
        n_checks++;
        if ({imem_req_o, stallreq_o} !== 2'b00)
            $display("FAIL rm_rst_comb: got req %b stallreq %b, want 0 0",
                     imem_req_o, stallreq_o);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0)
            $display("FAIL rm_id: got pc %h inst %h, want 0 0", id_pc_o, id_inst_o);
        else n_pass++;
        imem_ack_i = 1'b0;
        waited     = 0;
        delay_map.delete();
        rst        = 1'b0;
        drive();
        n_checks++;
        if (imem_req_o !== 1'b0)
            $display("FAIL rm_idle: got %b, want 0", imem_req_o);
        else n_pass++;
        tick();
        drive();
        n_checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0})
            $display("FAIL rm_restart: got req %b addr %h, want 1 00000000",
                     imem_req_o, imem_addr_o);
        else n_pass++;
        exp_q.push_back('{pc: 32'h0, inst: mem_word(32'h0)});
        tick();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL rm_drain: got %0d pending, want 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst             = 1'b1;
        stall_v         = 2'b00;
        imem_ack_i      = 1'b0;
        imem_rdata_i    = 32'h0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        test_reset();
        test_zero_wait();
        test_ack_delay();
        test_branch_late();
        test_branch_same();
        test_stall_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
